// File: rtl/uart_packet_receiver_if.sv
// uart_packet_receiver_if: serial line plus packet valid/ready and status bundle.
interface uart_packet_receiver_if #(parameter int PKT_BYTES = 16);
    logic                   rx;
    logic [PKT_BYTES*8-1:0] pkt_data;
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic                   busy;
    logic                   frame_err;
    logic                   timeout_err;
    logic                   overrun;
    logic                   chk_err;
    modport master (
        input  rx, pkt_ready,
        output pkt_data, pkt_valid, busy, frame_err, timeout_err, overrun, chk_err
    );
    modport slave (
        output rx, pkt_ready,
        input  pkt_data, pkt_valid, busy, frame_err, timeout_err, overrun, chk_err
    );
endinterface

// File: rtl/uart_packet_receiver.sv
// uart_packet_receiver: 8N1 UART deserialiser assembling PKT_BYTES-byte packets for a valid/ready consumer.
// Define CHECKSUM_EN to require the last byte to be the XOR of all preceding bytes.
module uart_packet_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PKT_BYTES    = 16,
    parameter int TIMEOUT_CLKS = 17360
) (
    input logic clk,
    input logic rst,
    uart_packet_receiver_if.master bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = PKT_BYTES > 1 ? $clog2(PKT_BYTES) : 1;
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST = CW'(PKT_BYTES - 1);
    localparam logic [IW-1:0] TLIM = IW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t                 state;
    logic                   rx_meta, rx_sync, rx_prev, stop_hold, chk_ok;
    logic [TW-1:0]          bit_tmr;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic [CW-1:0]          byte_cnt;
    logic [IW-1:0]          idle_cnt;
    logic [PKT_BYTES*8-1:0] pkt_buf, pkt_next;

    always_comb begin
        pkt_next = pkt_buf;
        pkt_next[{byte_cnt, 3'b000} +: 8] = shift;
    end

`ifdef CHECKSUM_EN
    logic [7:0] chk;
    // Running XOR of the bytes stored so far; restarts with byte 0 of each packet.
    always_ff @(posedge clk)
        if (rst)
            chk <= '0;
        else if (state == STOP && !stop_hold && bit_tmr == FULL && rx_sync)
            chk <= byte_cnt == '0 ? shift : chk ^ shift;
    assign chk_ok = shift == chk;
`else
    assign chk_ok = 1'b1;
`endif

    assign bus.busy = state != IDLE || byte_cnt != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta         <= 1'b1;
            rx_sync         <= 1'b1;
            rx_prev         <= 1'b1;
            state           <= IDLE;
            stop_hold       <= 1'b0;
            bit_tmr         <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            byte_cnt        <= '0;
            idle_cnt        <= '0;
            pkt_buf         <= '0;
            bus.pkt_data    <= '0;
            bus.pkt_valid   <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.chk_err     <= 1'b0;
        end else begin
            rx_meta         <= bus.rx;
            rx_sync         <= rx_meta;
            rx_prev         <= rx_sync;
            bus.frame_err   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.chk_err     <= 1'b0;
            bit_tmr         <= bit_tmr + 1'b1;
            idle_cnt        <= '0;
            if (bus.pkt_valid && bus.pkt_ready)
                bus.pkt_valid <= 1'b0;
            case (state)
                IDLE:
                    if (rx_prev && !rx_sync) begin
                        state   <= START;
                        bit_tmr <= '0;
                    end else if (byte_cnt != '0) begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == TLIM) begin
                            bus.timeout_err <= 1'b1;
                            byte_cnt        <= '0;
                        end
                    end
                START:
                    if (bit_tmr == HALF) begin
                        state   <= rx_sync ? IDLE : DATA;
                        bit_tmr <= '0;
                        bit_idx <= '0;
                    end
                DATA:
                    if (bit_tmr == FULL) begin
                        shift   <= {rx_sync, shift[7:1]};
                        bit_tmr <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                STOP:
                    if (stop_hold) begin
                        if (rx_sync) begin
                            stop_hold <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (bit_tmr == FULL) begin
                        if (rx_sync) begin
                            state    <= IDLE;
                            pkt_buf  <= pkt_next;
                            byte_cnt <= byte_cnt == LAST ? '0 : byte_cnt + 1'b1;
                            if (byte_cnt == LAST) begin
                                if (!chk_ok)
                                    bus.chk_err <= 1'b1;
                                else if (bus.pkt_valid && !bus.pkt_ready)
                                    bus.overrun <= 1'b1;
                                else begin
                                    bus.pkt_data  <= pkt_next;
                                    bus.pkt_valid <= 1'b1;
                                end
                            end
                        end else begin
                            bus.frame_err <= 1'b1;
                            byte_cnt      <= '0;
                            stop_hold     <= 1'b1;
                        end
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_packet_receiver.sv
// tb_uart_packet_receiver: directed and randomized UART traffic checked against a byte-level packet model.
module tb_uart_packet_receiver;
    localparam int CPB = 16, PB = 16, TMO = 320, CLK_P = 10, BIT = CPB * CLK_P;

    logic clk = 1'b0, rst = 1'b1;
    always #(CLK_P / 2) clk = ~clk;

    uart_packet_receiver_if #(.PKT_BYTES(PB)) bus ();
    uart_packet_receiver #(.CLKS_PER_BIT(CPB), .PKT_BYTES(PB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0, errors = 0;
    int ferr_cnt = 0, tmo_cnt = 0, ovr_cnt = 0, chk_cnt = 0;
    int exp_ferr = 0, exp_tmo = 0, exp_ovr = 0, exp_chk = 0;
    longint t_tmo = 0, t_stop = 0;
    logic [PB*8-1:0] got_q[$];
    logic [PB*8-1:0] exp_q[$];
    logic [PB*8-1:0] held_pkt = '0;
    logic [7:0] cur[$];
    logic [7:0] pkt_b[PB];
    bit held = 0;

    // Observe what the DUT sees at each active edge: transfers and pulse cycles.
    always @(posedge clk) if (!rst) begin
        if (bus.pkt_valid && bus.pkt_ready) got_q.push_back(bus.pkt_data);
        if (bus.frame_err) ferr_cnt++;
        if (bus.timeout_err) begin tmo_cnt++; t_tmo = $time; end
        if (bus.overrun) ovr_cnt++;
        if (bus.chk_err) chk_cnt++;
    end

    task automatic check(input string tag, input logic [PB*8-1:0] got, input logic [PB*8-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Packet-level model: bytes accumulate until PB are collected, then a packet is judged.
    task automatic model_frame(input logic [7:0] b, input bit stop);
        logic [PB*8-1:0] pk;
        logic [7:0] x;
        bit bad;
        if (!stop) begin
            cur.delete();
            exp_ferr++;
        end else begin
            cur.push_back(b);
            if (cur.size() == PB) begin
                pk = '0;
                x = '0;
                bad = 0;
                for (int i = 0; i < PB; i++) pk[i*8 +: 8] = cur[i];
`ifdef CHECKSUM_EN
                for (int i = 0; i < PB - 1; i++) x ^= cur[i];
                bad = x != cur[PB-1];
`endif
                cur.delete();
                if (bad) exp_chk++;
                else if (held) exp_ovr++;
                else if (bus.pkt_ready) exp_q.push_back(pk);
                else begin held = 1; held_pkt = pk; end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop, input int bns);
        bus.rx = 1'b0;
        #(bns);
        for (int i = 0; i < 8; i++) begin bus.rx = b[i]; #(bns); end
        t_stop = $time;
        bus.rx = stop;
        #(bns);
        bus.rx = 1'b1;
        if (!stop) #(bns * 2);
        model_frame(b, stop);
    endtask

    task automatic fill_pkt(input logic [7:0] first);
        logic [7:0] x;
        pkt_b[0] = first;
        x = first;
        for (int i = 1; i < PB; i++) pkt_b[i] = 8'($urandom);
`ifdef CHECKSUM_EN
        for (int i = 1; i < PB - 1; i++) x ^= pkt_b[i];
        pkt_b[PB-1] = x;
`endif
    endtask

    task automatic send_pkt(input int bns);
        for (int i = 0; i < PB; i++) begin
            send_byte(pkt_b[i], 1'b1, bns);
            #($urandom_range(0, 300));
        end
    endtask

    task automatic sync_check(input string tag);
        #(BIT);
        check({tag, " frame_err"}, ferr_cnt, exp_ferr);
        check({tag, " timeout"}, tmo_cnt, exp_tmo);
        check({tag, " overrun"}, ovr_cnt, exp_ovr);
        check({tag, " chk_err"}, chk_cnt, exp_chk);
        check({tag, " pkt count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, " pkt data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int bn[4] = '{158, 160, 163, 166};
        bus.rx = 1'b1;
        bus.pkt_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset flags", {bus.pkt_valid, bus.busy, bus.frame_err, bus.timeout_err, bus.overrun, bus.chk_err}, '0);
        check("reset data", bus.pkt_data, '0);
        rst = 1'b0;
        #(BIT);
        for (int r = 0; r < 2; r++) begin
            pkt_b[0] = 8'h04;
            for (int i = 1; i < PB; i++) pkt_b[i] = 8'hFF;
            send_pkt(r == 0 ? BIT : BIT - 2);
            sync_check("t1 pattern");
        end
        fill_pkt(8'h55);
        for (int i = 0; i < 5; i++) send_byte(pkt_b[i], 1'b1, BIT);
        send_byte(pkt_b[5], 1'b0, BIT);
        sync_check("t2 bad stop");
        check("t2 busy", bus.busy, 0);
        fill_pkt(8'h06);
        send_pkt(BIT);
        sync_check("t2 next pkt");
        fill_pkt(8'h21);
        for (int i = 0; i < 7; i++) send_byte(pkt_b[i], 1'b1, BIT);
        #(CLK_P * 4);
        check("t3 busy mid", bus.busy, 1);
        #(CLK_P * 400);
        exp_tmo++;
        cur.delete();
        check("t3 busy after", bus.busy, 0);
        check("t3 timeout window", (t_tmo - t_stop >= TMO * CLK_P + 50) && (t_tmo - t_stop <= TMO * CLK_P + 250), 1);
        sync_check("t3 timeout");
        fill_pkt(8'h09);
        send_pkt(BIT);
        sync_check("t3 next pkt");
        bus.pkt_ready = 1'b0;
        fill_pkt(8'h03);
        send_pkt(BIT);
        fill_pkt(8'h0C);
        send_pkt(BIT);
        #(BIT);
        check("t4 valid held", bus.pkt_valid, 1);
        check("t4 held data", bus.pkt_data, held_pkt);
        @(negedge clk);
        #2 bus.pkt_ready = 1'b1;
        if (held) begin exp_q.push_back(held_pkt); held = 0; end
        @(negedge clk);
        check("t4 valid drop", bus.pkt_valid, 0);
        sync_check("t4 overrun");
        for (int p = 0; p < 6; p++) begin
            fill_pkt(8'($urandom));
`ifdef CHECKSUM_EN
            if ($urandom_range(0, 1) == 0) pkt_b[PB-1] ^= 8'h01;
`endif
            for (int i = 0; i < PB; i++) begin
                send_byte(pkt_b[i], $urandom_range(0, 39) != 0, bn[$urandom_range(0, 3)]);
                #($urandom_range(0, 300));
            end
            sync_check("rand pkt");
        end
        #(CLK_P * 400);
        if (cur.size() > 0) begin exp_tmo++; cur.delete(); end
        sync_check("rand tail");
        bus.rx = 1'b0;
        #(CLK_P * 5);
        bus.rx = 1'b1;
        #(BIT * 2);
        check("t5 glitch busy", bus.busy, 0);
        sync_check("t5 glitch");
        fill_pkt(8'h5A);
        send_byte(pkt_b[0], 1'b1, BIT);
        send_byte(pkt_b[1], 1'b1, BIT);
        bus.rx = 1'b0;
        #(BIT * 3);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5 reset flags", {bus.pkt_valid, bus.busy, bus.frame_err, bus.timeout_err, bus.overrun, bus.chk_err}, '0);
        check("t5 reset data", bus.pkt_data, '0);
        bus.rx = 1'b1;
        @(negedge clk) rst = 1'b0;
        cur.delete();
        held = 0;
        #(BIT * 2);
        fill_pkt(8'h11);
        send_pkt(BIT);
        sync_check("t5 after reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
